tdm_demultiplexer_1_to_4: RTL and testbench
===========================================

Name: tdm_demultiplexer_1_to_4

Overview:
Receiving end of the 4-to-1 line multiplexer path. It drives the 2-bit slot select that steers an upstream 4-to-1 mux, samples the single multiplexed line once per slot, and reassembles the four slots into parallel output lines. A completed frame is presented with a one-cycle valid pulse. Frame-sync violations are flagged.

Parameters:
DATA_WIDTH, 1, width of each slot (bits carried on the multiplexed line per cycle)

Ports:
clock  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
frame_start  input  1  marks that the current cycle carries slot 0 of a new frame
in_line  input  DATA_WIDTH  multiplexed data line, output of the upstream 4-to-1 mux
select_lines  output  2  registered slot index expected on in_line this cycle; drives the upstream mux select
output_lines  output  4*DATA_WIDTH  last complete frame; slot i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
frame_valid  output  1  one-cycle pulse when output_lines updates
frame_error  output  1  one-cycle pulse on a frame-sync violation

Behaviour:
- Reset (synchronous, active-high): state=IDLE, select_lines=0, shadow register=0, output_lines=0, frame_valid=0, frame_error=0.
- Reset mid-frame: partial frame discarded; output_lines cleared; no valid pulse and no error pulse.
- The FSM has two states, IDLE and RECEIVE. select_lines is registered and equals the slot index sampled at the next edge.
- IDLE:
  - select_lines=0.
  - On an edge with frame_start=1: capture in_line into shadow slot 0, set select_lines=1, go to RECEIVE.
  - With frame_start=0: remain in IDLE and ignore in_line.
- RECEIVE, frame_start=0:
  - Capture in_line into shadow slot[select_lines].
  - At slots 1 and 2: increment select_lines.
  - At slot 3: load output_lines with shadow slots 0..2 plus the current in_line as slot 3, in the same edge. Set frame_valid=1 for the following cycle, select_lines=0, and go to IDLE.
- RECEIVE, frame_start=1 (sync violation at any slot 1..3):
  - Assert frame_error=1 for the following cycle.
  - Discard the partial frame; output_lines is held.
  - Treat the cycle as slot 0 of a new frame: capture into slot 0, select_lines=1, stay in RECEIVE.
- Latency: frame_start sampled at edge E0 means slots are captured at E0..E3. output_lines and frame_valid change at E3, so they are visible in the cycle after E3. frame_valid deasserts at E4 unless that edge also completes a frame (impossible: a minimum of 4 cycles separates completions).
- Back-to-back frames: frame_start may be asserted in the cycle immediately after slot 3 (state IDLE). There are no gap cycles and the throughput is one frame per 4 cycles.
- output_lines holds its value between completions. Shadow contents are never visible on the outputs.
- frame_valid and frame_error are never both 1 in the same cycle.
- Widths: select_lines wraps 3→0 only through the completion path; it never counts past 3. All data paths are exactly DATA_WIDTH per slot, with no extension or truncation.

Test Plan:
- Reset: hold reset 2 cycles with random in_line → all outputs 0; select_lines=0; state IDLE.
- Single frame, DATA_WIDTH=1: frame_start high one cycle, in_line=1,0,1,1 on consecutive cycles → select_lines sequence 0,1,2,3,0. output_lines=4'b1101 and frame_valid=1 for exactly one cycle, 4 cycles after frame_start.
- Loopback through the 4-to-1 mux: mux input_lines=4'b1101, mux select driven by select_lines, frame_start pulsed once → output_lines=4'b1101. Repeating with input_lines=4'b0110 → 4'b0110 on the next frame.
- Back-to-back: two frames with no gap (1,1,0,0 then 0,0,1,0) → valid pulses 4 cycles apart. output_lines=4'b0011, then 4'b0100.
- Sync violation: frame_start re-asserted at slot 2 of a frame, then a clean frame 0,1,1,1 follows from that cycle → frame_error pulses once. No valid for the aborted frame; previous output_lines held; then output_lines=4'b1110 with one valid pulse.
- Mid-frame reset: reset asserted at slot 1 → next cycle all outputs 0. A following frame 1,0,0,1 → output_lines=4'b1001.

Source files
------------

// File: rtl/tdm_demultiplexer_1_to_4.sv
`default_nettype none
// ============================================================================
//  Module   : tdm_demultiplexer_1_to_4
//  Brief    : Drives the slot select of an upstream 4:1 mux, samples one slot
//             per cycle and presents each completed frame in parallel.
//  Revision : 1.0 - initial release
// ============================================================================
module tdm_demultiplexer_1_to_4 #(
  parameter int DATA_WIDTH = 1
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      frame_start,
  input  logic [DATA_WIDTH-1:0]     in_line,
  output logic [1:0]                select_lines,
  output logic [4*DATA_WIDTH-1:0]   output_lines,
  output logic                      frame_valid,
  output logic                      frame_error
);

  localparam int c_NUM_SLOTS = 4;
  localparam logic [1:0] c_LAST_SLOT = 2'd3;

  typedef enum logic [0:0] {
    ST_IDLE    = 1'b0,
    ST_RECEIVE = 1'b1
  } state_t;

  state_t                          r_state;
  state_t                          w_state_nxt;
  logic [1:0]                      r_select;
  logic [1:0]                      w_select_nxt;
  logic [DATA_WIDTH-1:0]           r_shadow [0:c_NUM_SLOTS-1];
  logic [c_NUM_SLOTS-1:0]          w_slot_we;
  logic [c_NUM_SLOTS*DATA_WIDTH-1:0] w_frame;
  logic [c_NUM_SLOTS*DATA_WIDTH-1:0] r_output;
  logic                            w_load_frame;
  logic                            w_valid_nxt;
  logic                            w_error_nxt;
  logic                            r_valid;
  logic                            r_error;

  always_comb begin
    w_state_nxt  = r_state;
    w_select_nxt = r_select;
    w_slot_we    = '0;
    w_load_frame = 1'b0;
    w_valid_nxt  = 1'b0;
    w_error_nxt  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_select_nxt = 2'd0;
        if (frame_start) begin
          w_slot_we[0] = 1'b1;
          w_select_nxt = 2'd1;
          w_state_nxt  = ST_RECEIVE;
        end
      end
      ST_RECEIVE: begin
        if (frame_start) begin
          // Sync slip: abandon the partial frame and restart at slot 0.
          w_error_nxt  = 1'b1;
          w_slot_we[0] = 1'b1;
          w_select_nxt = 2'd1;
        end else if (r_select == c_LAST_SLOT) begin
          w_load_frame = 1'b1;
          w_valid_nxt  = 1'b1;
          w_select_nxt = 2'd0;
          w_state_nxt  = ST_IDLE;
        end else begin
          w_slot_we[r_select] = 1'b1;
          w_select_nxt        = r_select + 2'd1;
        end
      end
      default: begin
        w_select_nxt = 2'd0;
        w_state_nxt  = ST_IDLE;
      end
    endcase
  end

  // Slot 3 bypasses the shadow so the frame is published on its capture edge.
  generate
    for (genvar i = 0; i < c_NUM_SLOTS; i++) begin : g_frame
      if (i == c_NUM_SLOTS - 1) begin : g_live
        assign w_frame[i*DATA_WIDTH +: DATA_WIDTH] = in_line;
      end else begin : g_held
        assign w_frame[i*DATA_WIDTH +: DATA_WIDTH] = r_shadow[i];
      end
    end
  endgenerate

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_select <= 2'd0;
      r_output <= '0;
      r_valid  <= 1'b0;
      r_error  <= 1'b0;
      for (int i = 0; i < c_NUM_SLOTS; i++) begin
        r_shadow[i] <= '0;
      end
    end else begin
      r_state  <= w_state_nxt;
      r_select <= w_select_nxt;
      r_valid  <= w_valid_nxt;
      r_error  <= w_error_nxt;
      if (w_load_frame) begin
        r_output <= w_frame;
      end
      for (int i = 0; i < c_NUM_SLOTS; i++) begin
        if (w_slot_we[i]) begin
          r_shadow[i] <= in_line;
        end
      end
    end
  end

  assign select_lines = r_select;
  assign output_lines = r_output;
  assign frame_valid  = r_valid;
  assign frame_error  = r_error;

endmodule
`default_nettype wire

// File: tb/tb_tdm_demultiplexer_1_to_4.sv
`default_nettype none
// ============================================================================
//  Module   : tb_tdm_demultiplexer_1_to_4
//  Brief    : Directed bench with a slot-counting frame model and a per-cycle
//             compare, plus literal checks on hand-computed frames.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_tdm_demultiplexer_1_to_4;

  localparam int DW = 1;

  logic            clock = 1'b0;
  logic            reset = 1'b1;
  logic            frame_start = 1'b0;
  logic [DW-1:0]   drv_data = '0;
  logic            loopback = 1'b0;
  logic [4*DW-1:0] mux_in = '0;
  logic [DW-1:0]   in_line;
  logic [1:0]      select_lines;
  logic [4*DW-1:0] output_lines;
  logic            frame_valid;
  logic            frame_error;

  int n_checks = 0;
  int n_fail   = 0;

  // Upstream 4:1 mux steered by the DUT's own select.
  assign in_line = loopback ? mux_in[select_lines*DW +: DW] : drv_data;

  tdm_demultiplexer_1_to_4 #(.DATA_WIDTH(DW)) dut (
    .clock        (clock),
    .reset        (reset),
    .frame_start  (frame_start),
    .in_line      (in_line),
    .select_lines (select_lines),
    .output_lines (output_lines),
    .frame_valid  (frame_valid),
    .frame_error  (frame_error)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: pos = -1 when no frame is open, else the slot expected next.
  int            m_pos = -1;
  logic [DW-1:0] m_slot [0:3];
  logic [4*DW-1:0] m_out = '0;
  logic [1:0]    m_sel = 2'd0;
  logic          m_valid = 1'b0;
  logic          m_err = 1'b0;
  bit            m_live = 1'b0;

  always @(posedge clock) begin
    m_valid = 1'b0;
    m_err   = 1'b0;
    if (reset) begin
      m_pos  = -1;
      m_out  = '0;
      m_live = 1'b1;
    end else if (frame_start) begin
      if (m_pos != -1) m_err = 1'b1;
      m_slot[0] = in_line;
      m_pos = 1;
    end else if (m_pos >= 1) begin
      m_slot[m_pos] = in_line;
      if (m_pos == 3) begin
        for (int k = 0; k < 4; k++) m_out[k*DW +: DW] = m_slot[k];
        m_valid = 1'b1;
        m_pos = -1;
      end else begin
        m_pos = m_pos + 1;
      end
    end
    m_sel = (m_pos == -1) ? 2'd0 : 2'(m_pos);
  end

  always @(negedge clock) begin
    if (m_live) begin
      chk("cyc_select", 32'(select_lines), 32'(m_sel));
      chk("cyc_output", 32'(output_lines), 32'(m_out));
      chk("cyc_valid",  32'(frame_valid),  32'(m_valid));
      chk("cyc_error",  32'(frame_error),  32'(m_err));
      chk("cyc_exclusive", 32'(frame_valid & frame_error), 32'd0);
    end
  end

  task automatic step(input logic r, input logic fs, input logic [DW-1:0] d);
    reset       = r;
    frame_start = fs;
    drv_data    = d;
    @(posedge clock);
    #1;
  endtask

  task automatic send_frame(input logic [3:0] bits);
    for (int k = 0; k < 4; k++) step(1'b0, (k == 0), bits[k]);
  endtask

  initial begin
    // Reset for two cycles with random data on the line.
    step(1'b1, 1'b0, DW'($urandom));
    step(1'b1, 1'b1, DW'($urandom));
    chk("rst_output", 32'(output_lines), 32'd0);
    chk("rst_select", 32'(select_lines), 32'd0);
    chk("rst_valid",  32'(frame_valid),  32'd0);
    chk("rst_error",  32'(frame_error),  32'd0);

    // Idle cycles ignore the line.
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    chk("idle_select", 32'(select_lines), 32'd0);
    chk("idle_output", 32'(output_lines), 32'd0);

    // Single frame 1,0,1,1.
    step(1'b0, 1'b1, 1'b1);
    chk("single_sel1", 32'(select_lines), 32'd1);
    step(1'b0, 1'b0, 1'b0);
    chk("single_sel2", 32'(select_lines), 32'd2);
    step(1'b0, 1'b0, 1'b1);
    chk("single_sel3", 32'(select_lines), 32'd3);
    chk("single_novalid", 32'(frame_valid), 32'd0);
    step(1'b0, 1'b0, 1'b1);
    chk("single_sel0", 32'(select_lines), 32'd0);
    chk("single_valid", 32'(frame_valid), 32'd1);
    chk("single_output", 32'(output_lines), 32'hD);
    step(1'b0, 1'b0, 1'b0);
    chk("single_valid_drop", 32'(frame_valid), 32'd0);
    chk("single_hold", 32'(output_lines), 32'hD);

    // Loopback through the mux.
    loopback = 1'b1;
    mux_in = 4'b1101;
    send_frame(4'b0000);
    chk("loop_1101", 32'(output_lines), 32'hD);
    chk("loop_valid", 32'(frame_valid), 32'd1);
    mux_in = 4'b0110;
    send_frame(4'b0000);
    chk("loop_0110", 32'(output_lines), 32'h6);
    loopback = 1'b0;
    step(1'b0, 1'b0, 1'b0);

    // Back-to-back frames 1,1,0,0 then 0,0,1,0.
    send_frame(4'b0011);
    chk("b2b_first", 32'(output_lines), 32'h3);
    chk("b2b_valid1", 32'(frame_valid), 32'd1);
    step(1'b0, 1'b1, 1'b0);
    chk("b2b_gap_novalid", 32'(frame_valid), 32'd0);
    chk("b2b_gap_noerr", 32'(frame_error), 32'd0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0);
    chk("b2b_second", 32'(output_lines), 32'h4);
    chk("b2b_valid2", 32'(frame_valid), 32'd1);

    // Sync violation at slot 2, restarting a clean frame 0,1,1,1.
    step(1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b0);
    chk("viol_error", 32'(frame_error), 32'd1);
    chk("viol_novalid", 32'(frame_valid), 32'd0);
    chk("viol_hold", 32'(output_lines), 32'h4);
    chk("viol_select", 32'(select_lines), 32'd1);
    step(1'b0, 1'b0, 1'b1);
    chk("viol_error_drop", 32'(frame_error), 32'd0);
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    chk("viol_output", 32'(output_lines), 32'hE);
    chk("viol_valid", 32'(frame_valid), 32'd1);

    // Reset at slot 1, then frame 1,0,0,1.
    step(1'b0, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b0);
    chk("midrst_output", 32'(output_lines), 32'd0);
    chk("midrst_select", 32'(select_lines), 32'd0);
    chk("midrst_valid", 32'(frame_valid), 32'd0);
    chk("midrst_error", 32'(frame_error), 32'd0);
    send_frame(4'b1001);
    chk("midrst_frame", 32'(output_lines), 32'h9);
    chk("midrst_frame_valid", 32'(frame_valid), 32'd1);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);

    @(negedge clock);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
